// File: rtl/lzw_pkg.sv
// Shared constants and state encoding for the LZW decoder datapath.
package lzw_pkg;
    localparam int CODE_W   = 13;
    localparam int CHAR_W   = 8;
    localparam int STACK_AW = 13;

    localparam logic [CODE_W-1:0] FIRST_CODE = 13'd256;
    localparam logic [CODE_W-1:0] MAX_CODE   = 13'h1FFE;
    localparam logic [CODE_W-1:0] END_CODE   = 13'h1FFF;

    typedef enum logic [2:0] {
        IDLE,
        WALK,
        WAIT,
        UPD,
        POP
    } state_e;
endpackage

// File: rtl/lzw_char_stack.sv
// Synchronous LIFO holding decoded characters so they leave in forward order.
module lzw_char_stack #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] top_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          last_o
);
    logic [DW-1:0] mem_q [2**AW];
    logic [AW:0]   sp_q;
    logic [AW-1:0] top_idx;

    assign empty_o = (sp_q == '0);
    assign full_o  = sp_q[AW];
    assign last_o  = (sp_q == {{AW{1'b0}}, 1'b1});
    assign top_idx = sp_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
    assign top_o   = mem_q[top_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            sp_q <= sp_q + {{AW{1'b0}}, 1'b1};
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage is not reset: a cleared pointer already makes its contents invisible.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[sp_q[AW-1:0]] <= din_i;
        end
    end
endmodule

// File: rtl/lzw_decoder.sv
// LZW decompression engine: walks prefix chains in the dictionary RAM,
// stacks characters, adds one entry per code and streams characters out.
module lzw_decoder
    import lzw_pkg::*;
#(
    parameter int STACK_AW_P = STACK_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              code_vld,
    input  logic [CODE_W-1:0] code_in,
    output logic              code_rdy,
    output logic              dict_rd,
    output logic [CODE_W-1:0] dict_addr,
    input  logic [CODE_W-1:0] prefix_data,
    input  logic [CHAR_W-1:0] append_data,
    output logic              dict_wr,
    output logic [CODE_W-1:0] wr_prefix,
    output logic [CHAR_W-1:0] wr_append,
    output logic [CHAR_W-1:0] char_out,
    output logic              char_vld,
    input  logic              char_rdy,
    output logic              done,
    output logic              err
);
    state_e              state_q, state_d;
    logic [CODE_W-1:0]   cur_q, cur_d;
    logic [CODE_W-1:0]   lat_q, lat_d;
    logic [CODE_W-1:0]   old_q, old_d;
    logic [CHAR_W-1:0]   first_ch_q, first_ch_d;
    logic [CODE_W-1:0]   next_code_q, next_code_d;
    logic                have_old_q, have_old_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                code_rdy_q, code_rdy_d;
    logic                dict_rd_q, dict_rd_d;
    logic                dict_wr_q, dict_wr_d;
    logic [CODE_W-1:0]   dict_addr_q, dict_addr_d;
    logic [CODE_W-1:0]   wr_prefix_q, wr_prefix_d;
    logic [CHAR_W-1:0]   wr_append_q, wr_append_d;

    logic                push, pop;
    logic [CHAR_W-1:0]   push_data;
    logic [CHAR_W-1:0]   stk_top;
    logic                stk_empty, stk_full, stk_last;

    lzw_char_stack #(
        .AW(STACK_AW_P),
        .DW(CHAR_W)
    ) u_stack (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (push_data),
        .top_o  (stk_top),
        .empty_o(stk_empty),
        .full_o (stk_full),
        .last_o (stk_last)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        lat_d       = lat_q;
        old_d       = old_q;
        first_ch_d  = first_ch_q;
        next_code_d = next_code_q;
        have_old_d  = have_old_q;
        err_d       = err_q;
        done_d      = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        push_data   = '0;

        unique case (state_q)
            IDLE: begin
                if (code_vld && code_rdy_q) begin
                    lat_d = code_in;
                    cur_d = code_in;
                    if (code_in == END_CODE) begin
                        done_d      = 1'b1;
                        next_code_d = FIRST_CODE;
                        have_old_d  = 1'b0;
                        err_d       = 1'b0;
                    end else if (code_in > next_code_q ||
                                 (code_in == next_code_q && !have_old_q)) begin
                        err_d = 1'b1;
                    end else if (code_in == next_code_q) begin
                        // KwKwK: string is old + first char of old, so the trailing char goes in first.
                        push      = 1'b1;
                        push_data = first_ch_q;
                        cur_d     = old_q;
                        state_d   = WALK;
                    end else begin
                        state_d = WALK;
                    end
                end
            end
            WALK: begin
                if (cur_q < FIRST_CODE) begin
                    push       = 1'b1;
                    push_data  = cur_q[CHAR_W-1:0];
                    first_ch_d = cur_q[CHAR_W-1:0];
                    state_d    = UPD;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                push      = 1'b1;
                push_data = append_data;
                cur_d     = prefix_data;
                state_d   = WALK;
            end
            UPD: begin
                if (have_old_q && next_code_q <= MAX_CODE) begin
                    next_code_d = next_code_q + CODE_W'(1);
                end
                old_d      = lat_q;
                have_old_d = 1'b1;
                state_d    = POP;
            end
            POP: begin
                if (stk_empty) begin
                    state_d = IDLE;
                end else if (char_rdy) begin
                    pop = 1'b1;
                    if (stk_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push && stk_full) err_d = 1'b1;

        // Dictionary strobes are registered, so they are decided on entry to WALK/UPD.
        code_rdy_d  = (state_d == IDLE);
        dict_rd_d   = (state_d == WALK) && (cur_d >= FIRST_CODE);
        dict_wr_d   = (state_d == UPD) && (state_q != UPD) && have_old_q &&
                      (next_code_q <= MAX_CODE);
        dict_addr_d = dict_wr_d ? next_code_q : (dict_rd_d ? cur_d : '0);
        wr_prefix_d = dict_wr_d ? old_q : '0;
        wr_append_d = dict_wr_d ? first_ch_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            lat_q       <= '0;
            old_q       <= '0;
            first_ch_q  <= '0;
            next_code_q <= FIRST_CODE;
            have_old_q  <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            code_rdy_q  <= 1'b1;
            dict_rd_q   <= 1'b0;
            dict_wr_q   <= 1'b0;
            dict_addr_q <= '0;
            wr_prefix_q <= '0;
            wr_append_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            lat_q       <= lat_d;
            old_q       <= old_d;
            first_ch_q  <= first_ch_d;
            next_code_q <= next_code_d;
            have_old_q  <= have_old_d;
            err_q       <= err_d;
            done_q      <= done_d;
            code_rdy_q  <= code_rdy_d;
            dict_rd_q   <= dict_rd_d;
            dict_wr_q   <= dict_wr_d;
            dict_addr_q <= dict_addr_d;
            wr_prefix_q <= wr_prefix_d;
            wr_append_q <= wr_append_d;
        end
    end

    assign code_rdy  = code_rdy_q;
    assign dict_rd   = dict_rd_q;
    assign dict_wr   = dict_wr_q;
    assign dict_addr = dict_addr_q;
    assign wr_prefix = wr_prefix_q;
    assign wr_append = wr_append_q;
    assign done      = done_q;
    assign err       = err_q;
    assign char_vld  = (state_q == POP) && !stk_empty;
    assign char_out  = char_vld ? stk_top : '0;
endmodule

// File: tb/tb_lzw_decoder.sv
// Self-checking bench: behavioural dictionary RAM plus a string-level LZW reference model.
module tb_lzw_decoder;
    localparam int T_END  = 8191;
    localparam int T_MAX  = 8190;
    localparam int T_FIRST = 256;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        code_vld = 1'b0;
    logic [12:0] code_in = '0;
    logic        code_rdy;
    logic        dict_rd;
    logic [12:0] dict_addr;
    logic [12:0] prefix_data = '0;
    logic [7:0]  append_data = '0;
    logic        dict_wr;
    logic [12:0] wr_prefix;
    logic [7:0]  wr_append;
    logic [7:0]  char_out;
    logic        char_vld;
    logic        char_rdy = 1'b1;
    logic        done;
    logic        err;

    lzw_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_vld   (code_vld),
        .code_in    (code_in),
        .code_rdy   (code_rdy),
        .dict_rd    (dict_rd),
        .dict_addr  (dict_addr),
        .prefix_data(prefix_data),
        .append_data(append_data),
        .dict_wr    (dict_wr),
        .wr_prefix  (wr_prefix),
        .wr_append  (wr_append),
        .char_out   (char_out),
        .char_vld   (char_vld),
        .char_rdy   (char_rdy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Dictionary RAM, one-cycle read latency.
    logic [12:0] ram_p [8192];
    logic [7:0]  ram_a [8192];
    always @(posedge clk) begin
        if (dict_rd) begin
            prefix_data <= ram_p[dict_addr];
            append_data <= ram_a[dict_addr];
        end
        if (dict_wr) begin
            ram_p[dict_addr] <= wr_prefix;
            ram_a[dict_addr] <= wr_append;
        end
    end

    logic [7:0]  got_chars[$];
    logic [7:0]  exp_chars[$];
    logic [33:0] got_wr[$];
    logic [33:0] exp_wr[$];
    int          done_cnt = 0;
    int          exp_done = 0;
    int          tmo = 0;
    int          checks = 0;
    int          errors = 0;
    bit          rdy_mode = 1'b0;

    always @(negedge clk) begin
        if (rst_n && char_vld && char_rdy) got_chars.push_back(char_out);
        if (dict_wr) got_wr.push_back({dict_addr, wr_prefix, wr_append});
        if (rst_n && done) done_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode) char_rdy = ($urandom_range(0, 3) != 0);
    end

    // Reference model: every dictionary entry is kept as its full expanded string.
    bq_t mstr [8192];
    int  m_next = T_FIRST;
    bit  m_have_old = 1'b0;
    int  m_old = 0;
    bit  m_err = 1'b0;

    function automatic bq_t str_of(input int c);
        bq_t s;
        if (c < T_FIRST) s.push_back(8'(c));
        else s = mstr[c];
        return s;
    endfunction

    task automatic model_reset();
        m_next = T_FIRST;
        m_have_old = 1'b0;
        m_old = 0;
        m_err = 1'b0;
    endtask

    task automatic model_code(input int c);
        bq_t s;
        bq_t t;
        if (c == T_END) begin
            exp_done++;
            m_next = T_FIRST;
            m_have_old = 1'b0;
            m_err = 1'b0;
            return;
        end
        if (c > m_next || (c == m_next && !m_have_old)) begin
            m_err = 1'b1;
            return;
        end
        if (c == m_next) begin
            s = str_of(m_old);
            s.push_back(s[0]);
        end else begin
            s = str_of(c);
        end
        foreach (s[i]) exp_chars.push_back(s[i]);
        if (m_have_old && m_next <= T_MAX) begin
            t = str_of(m_old);
            t.push_back(s[0]);
            mstr[m_next] = t;
            exp_wr.push_back({13'(m_next), 13'(m_old), s[0]});
            m_next++;
        end
        m_old = c;
        m_have_old = 1'b1;
    endtask

    function automatic int diff_chars();
        int d;
        int n;
        n = (got_chars.size() < exp_chars.size()) ? got_chars.size() : exp_chars.size();
        d = got_chars.size() - exp_chars.size();
        if (d < 0) d = -d;
        for (int i = 0; i < n; i++) if (got_chars[i] !== exp_chars[i]) d++;
        return d;
    endfunction

    function automatic int diff_wr();
        int d;
        int n;
        n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        d = got_wr.size() - exp_wr.size();
        if (d < 0) d = -d;
        for (int i = 0; i < n; i++) if (got_wr[i] !== exp_wr[i]) d++;
        return d;
    endfunction

    task automatic clear_q();
        got_chars.delete();
        exp_chars.delete();
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic send_code(input int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!code_rdy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!code_rdy) begin
            tmo++;
            return;
        end
        code_vld = 1'b1;
        code_in  = 13'(c);
        @(posedge clk);
        #1;
        code_vld = 1'b0;
        model_code(c);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (n < 20000 && !(code_rdy && !char_vld && got_chars.size() >= exp_chars.size())) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) tmo++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (code_rdy !== 1'b1) begin errors++; $display("FAIL reset_code_rdy got %b want 1", code_rdy); end
        checks++; if (char_vld !== 1'b0) begin errors++; $display("FAIL reset_char_vld got %b want 0", char_vld); end
        checks++; if (dict_rd !== 1'b0 || dict_wr !== 1'b0) begin errors++; $display("FAIL reset_dict got rd=%b wr=%b want 0", dict_rd, dict_wr); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (char_out !== 8'd0 || dict_addr !== 13'd0) begin errors++; $display("FAIL reset_data got char=%0d addr=%0d want 0", char_out, dict_addr); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        clear_q();
    endtask

    task automatic test_basic();
        logic [7:0]  want_c [7];
        logic [33:0] want_w [3];
        int bad;
        want_c = '{8'd65, 8'd66, 8'd65, 8'd66, 8'd65, 8'd66, 8'd65};
        want_w = '{{13'd256, 13'd65, 8'd66}, {13'd257, 13'd66, 8'd65}, {13'd258, 13'd256, 8'd65}};
        clear_q();
        send_code(65);
        send_code(66);
        send_code(256);
        send_code(258);
        wait_idle();
        bad = (got_chars.size() == 7) ? 0 : 1;
        for (int i = 0; i < 7 && i < got_chars.size(); i++) if (got_chars[i] !== want_c[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL basic_chars got %0d chars (%0d bad) want ABABABA", got_chars.size(), bad); end
        bad = (got_wr.size() == 3) ? 0 : 1;
        for (int i = 0; i < 3 && i < got_wr.size(); i++) if (got_wr[i] !== want_w[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL basic_writes got %0d writes (%0d bad) want 3", got_wr.size(), bad); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", err); end
        checks++; if (tmo !== 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", tmo); tmo = 0; end
    endtask

    task automatic test_end();
        int d0;
        d0 = done_cnt;
        clear_q();
        send_code(T_END);
        repeat (3) @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL end_done_pulses got %0d want 1", done_cnt - d0); end
        send_code(67);
        wait_idle();
        checks++; if (got_chars.size() !== 1 || got_chars[0] !== 8'd67) begin errors++; $display("FAIL end_literal got %0d chars want 1 char 67", got_chars.size()); end
        checks++; if (got_wr.size() !== 0) begin errors++; $display("FAIL end_no_write got %0d want 0", got_wr.size()); end
        checks++; if (tmo !== 0) begin errors++; $display("FAIL end_timeout got %0d want 0", tmo); tmo = 0; end
    endtask

    task automatic test_bad_code();
        send_code(68);
        wait_idle();
        checks++; if (diff_wr() !== 0) begin errors++; $display("FAIL bad_setup_write got %0d diffs want 0", diff_wr()); end
        clear_q();
        send_code(300);
        @(negedge clk);
        checks++; if (code_rdy !== 1'b1) begin errors++; $display("FAIL bad_code_rdy got %b want 1", code_rdy); end
        checks++; if (err !== 1'b1 || m_err !== 1'b1) begin errors++; $display("FAIL bad_err got %b want 1", err); end
        repeat (5) @(negedge clk);
        checks++; if (got_chars.size() !== 0 || got_wr.size() !== 0) begin errors++; $display("FAIL bad_side_effects got chars=%0d writes=%0d want 0", got_chars.size(), got_wr.size()); end
        send_code(T_END);
        repeat (2) @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_clear got %b want 0", err); end
    endtask

    task automatic test_backpressure();
        logic [7:0] v0;
        int n;
        int unstable;
        clear_q();
        send_code(65);
        send_code(66);
        send_code(256);
        wait_idle();
        char_rdy = 1'b0;
        send_code(258);
        n = 0;
        while (!char_vld && n < 100) begin @(negedge clk); n++; end
        if (!char_vld) tmo++;
        v0 = char_out;
        unstable = 0;
        repeat (5) begin
            @(negedge clk);
            if (char_vld !== 1'b1 || char_out !== v0) unstable++;
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", unstable); end
        @(posedge clk);
        #1;
        char_rdy = 1'b1;
        wait_idle();
        checks++; if (diff_chars() !== 0) begin errors++; $display("FAIL bp_chars got %0d diffs (%0d chars) want 0 (%0d)", diff_chars(), got_chars.size(), exp_chars.size()); end
        checks++; if (diff_wr() !== 0) begin errors++; $display("FAIL bp_writes got %0d diffs want 0", diff_wr()); end
        checks++; if (tmo !== 0) begin errors++; $display("FAIL bp_timeout got %0d want 0", tmo); tmo = 0; end
    endtask

    task automatic test_random();
        int c;
        int d0;
        d0 = done_cnt;
        send_code(T_END);
        wait_idle();
        clear_q();
        rdy_mode = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (!m_have_old || $urandom_range(0, 3) == 0) c = int'($urandom_range(0, 255));
            else if ($urandom_range(0, 19) == 0) c = m_next + 1 + int'($urandom_range(0, 20));
            else c = int'($urandom_range(T_FIRST, m_next));
            send_code(c);
        end
        wait_idle();
        rdy_mode = 1'b0;
        @(posedge clk);
        #1;
        char_rdy = 1'b1;
        checks++; if (diff_chars() !== 0) begin errors++; $display("FAIL rand_chars got %0d diffs (%0d chars) want 0 (%0d)", diff_chars(), got_chars.size(), exp_chars.size()); end
        checks++; if (diff_wr() !== 0) begin errors++; $display("FAIL rand_writes got %0d diffs want 0", diff_wr()); end
        checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err got %b want %b", err, m_err); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rand_done got %0d want 1", done_cnt - d0); end
        checks++; if (tmo !== 0) begin errors++; $display("FAIL rand_timeout got %0d want 0", tmo); tmo = 0; end
    endtask

    task automatic test_fill();
        int c;
        send_code(T_END);
        wait_idle();
        clear_q();
        while (m_next < T_END && tmo == 0) send_code(int'($urandom_range(0, 255)));
        wait_idle();
        checks++; if (diff_wr() !== 0 || got_wr.size() !== T_MAX - T_FIRST + 1) begin errors++; $display("FAIL fill_writes got %0d writes (%0d diffs) want %0d", got_wr.size(), diff_wr(), T_MAX - T_FIRST + 1); end
        checks++; if (diff_chars() !== 0) begin errors++; $display("FAIL fill_chars got %0d diffs want 0", diff_chars()); end
        clear_q();
        for (int k = 0; k < 40; k++) begin
            c = (k % 2 == 0) ? int'($urandom_range(7900, T_MAX)) : int'($urandom_range(0, T_MAX));
            send_code(c);
        end
        wait_idle();
        checks++; if (got_wr.size() !== 0) begin errors++; $display("FAIL full_no_write got %0d want 0", got_wr.size()); end
        checks++; if (diff_chars() !== 0 || exp_chars.size() == 0) begin errors++; $display("FAIL full_chars got %0d diffs want 0", diff_chars()); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err got %b want 0", err); end
        checks++; if (tmo !== 0) begin errors++; $display("FAIL fill_timeout got %0d want 0", tmo); tmo = 0; end
    endtask

    task automatic test_reset_mid();
        int seen;
        int n;
        int wb;
        send_code(T_END);
        wait_idle();
        send_code(65);
        send_code(66);
        send_code(256);
        send_code(257);
        send_code(258);
        send_code(259);
        wait_idle();
        clear_q();
        send_code(260);
        seen = dict_rd ? 1 : 0;
        n = 0;
        while (seen < 3 && n < 100) begin
            @(negedge clk);
            if (dict_rd) seen++;
            n++;
        end
        if (seen < 3) tmo++;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        wb = got_wr.size();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (code_rdy !== 1'b1) begin errors++; $display("FAIL mid_code_rdy got %b want 1", code_rdy); end
        checks++; if (char_vld !== 1'b0) begin errors++; $display("FAIL mid_char_vld got %b want 0", char_vld); end
        checks++; if (got_wr.size() !== wb || wb !== 0) begin errors++; $display("FAIL mid_no_write got %0d want 0", got_wr.size()); end
        model_reset();
        clear_q();
        send_code(65);
        send_code(66);
        wait_idle();
        checks++; if (got_wr.size() !== 1 || got_wr[0] !== {13'd256, 13'd65, 8'd66}) begin errors++; $display("FAIL mid_next_code got %0d writes want 1 at 256", got_wr.size()); end
        checks++; if (diff_chars() !== 0) begin errors++; $display("FAIL mid_stack_empty got %0d diffs want 0", diff_chars()); end
        checks++; if (tmo !== 0) begin errors++; $display("FAIL mid_timeout got %0d want 0", tmo); tmo = 0; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_end();
        test_bad_code();
        test_backpressure();
        test_random();
        test_fill();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
